// File: rtl/pulse_cond_if.sv
// Signal bundle between the pulse conditioning stage and its surroundings.
// The environment (master) drives the controls and the raw pulse; the
// conditioning stage (slave) returns the cleaned pulse, edge strobes,
// timestamp and diagnostics.
//
// Flow semantics: there is no valid/ready pair on this bundle. Every output
// is a registered value that is meaningful on every clock after reset, and
// the consumer cannot apply backpressure. A strobe (edge_rise, edge_fall,
// pulse_full) is an event for exactly the one cycle it is high.
interface pulse_cond_if #(
    parameter int FILT_W   = 8,
    parameter int GLITCH_W = 16
);
    logic                ena;
    logic                pulse_in;
    logic [FILT_W-1:0]   filt_len;
    logic                glitch_clr;
    logic                pulse;
    logic                edge_rise;
    logic                edge_fall;
    logic [31:0]         count;
    logic                pulse_full;
    logic [GLITCH_W-1:0] glitch_cnt;

    modport master (
        output ena, pulse_in, filt_len, glitch_clr,
        input  pulse, edge_rise, edge_fall, count, pulse_full, glitch_cnt
    );

    modport slave (
        input  ena, pulse_in, filt_len, glitch_clr,
        output pulse, edge_rise, edge_fall, count, pulse_full, glitch_cnt
    );
endinterface

// File: rtl/pulse_cond.sv
// Front-end conditioning for the pulse period/width measurement block.
// Synchronises the raw pulse, rejects glitches shorter than filt_len+1
// enabled cycles, produces the free-running timestamp with its wrap strobe,
// and counts rejected glitches for diagnostics.
// CNT_RST is the value count takes on reset; it is 0 in every real use and
// only exists so a simulation can reach the 32-bit wrap quickly.
module pulse_cond #(
    parameter int          FILT_W   = 8,
    parameter int          GLITCH_W = 16,
    parameter logic [31:0] CNT_RST  = 32'h0
) (
    input  logic         clk,
    input  logic         rst,
    pulse_cond_if.slave  bus
);

    logic                s1;
    logic                s2;
    logic                pulse_q;
    logic                edge_rise_q;
    logic                edge_fall_q;
    logic [FILT_W-1:0]   stab;
    logic [31:0]         count_q;
    logic                pulse_full_q;
    logic [GLITCH_W-1:0] glitch_q;

    logic                mismatch;
    logic                stable_enough;
    logic                glitch_hit;

    // Decode the filter decision for the current cycle.
    always_comb begin
        mismatch      = (s2 != pulse_q);
        stable_enough = (stab >= bus.filt_len);
        glitch_hit    = bus.ena && !mismatch && (stab != '0);
    end

    // Two-flop synchroniser; runs regardless of ena so it never holds stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= bus.pulse_in;
            s2 <= s1;
        end
    end

    // Stability filter: flip only after filt_len+1 consecutive enabled
    // mismatching cycles; a mismatch run that ends early is a glitch. The >=
    // compare lets a lowered filt_len take effect on the next mismatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_q     <= 1'b0;
            stab        <= '0;
            edge_rise_q <= 1'b0;
            edge_fall_q <= 1'b0;
        end else begin
            edge_rise_q <= 1'b0;
            edge_fall_q <= 1'b0;
            if (bus.ena) begin
                if (mismatch) begin
                    if (stable_enough) begin
                        pulse_q     <= s2;
                        stab        <= '0;
                        edge_rise_q <= s2;
                        edge_fall_q <= !s2;
                    end else begin
                        stab <= stab + FILT_W'(1);
                    end
                end else if (stab != '0) begin
                    stab <= '0;
                end
            end
        end
    end

    // Saturating rejected-glitch counter; a clear wins over a same-cycle glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_q <= '0;
        end else if (bus.glitch_clr) begin
            glitch_q <= '0;
        end else if (glitch_hit && (glitch_q != '1)) begin
            glitch_q <= glitch_q + GLITCH_W'(1);
        end
    end

    // Timestamp counter; pulse_full marks the cycle in which count shows 0
    // after rolling over, so a reset value of 0 never raises it.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= CNT_RST;
            pulse_full_q <= 1'b0;
        end else begin
            pulse_full_q <= 1'b0;
            if (bus.ena) begin
                count_q      <= count_q + 32'd1;
                pulse_full_q <= (count_q == 32'hFFFF_FFFF);
            end
        end
    end

    // All outputs come straight from flops clocked on the same edge.
    always_comb begin
        bus.pulse      = pulse_q;
        bus.edge_rise  = edge_rise_q;
        bus.edge_fall  = edge_fall_q;
        bus.count      = count_q;
        bus.pulse_full = pulse_full_q;
        bus.glitch_cnt = glitch_q;
    end

endmodule

// File: tb/tb_pulse_cond.sv
// Bench for pulse_cond. Two instances share the same stimulus: bus_a is the
// production configuration; bus_b has an 8-bit glitch counter and a count
// reset value near the wrap so saturation and rollover are reachable quickly.
// A behavioural model predicts every cycle's outputs into expected queues;
// a monitor on the falling edge pops and compares. Directed checks with
// hand-derived constants cover the scenarios of interest.
module tb_pulse_cond;

    localparam int          W     = 52;
    localparam logic [31:0] B_RST = 32'hFFFF_FFF0;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       pulse_in;
    logic [7:0] filt_len;
    logic       glitch_clr;

    int n_checks = 0;
    int n_fail   = 0;

    pulse_cond_if #(.FILT_W(8), .GLITCH_W(16)) bus_a ();
    pulse_cond_if #(.FILT_W(8), .GLITCH_W(8))  bus_b ();

    assign bus_a.ena        = ena;
    assign bus_a.pulse_in   = pulse_in;
    assign bus_a.filt_len   = filt_len;
    assign bus_a.glitch_clr = glitch_clr;
    assign bus_b.ena        = ena;
    assign bus_b.pulse_in   = pulse_in;
    assign bus_b.filt_len   = filt_len;
    assign bus_b.glitch_clr = glitch_clr;

    pulse_cond #(.FILT_W(8), .GLITCH_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    pulse_cond #(.FILT_W(8), .GLITCH_W(8), .CNT_RST(B_RST)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Per instance: a two-cycle delay line for the synchroniser, the current
    // clean level, the length of the current enabled mismatch run, and the
    // number of enabled cycles seen since reset (mod 2^32) for the timestamp.
    bit              m_dly1 [2];
    bit              m_dly2 [2];
    bit              m_pulse[2];
    bit              m_er   [2];
    bit              m_ef   [2];
    bit              m_pf   [2];
    int unsigned     m_run  [2];
    int unsigned     m_gl   [2];
    longint unsigned m_cnt  [2];
    int unsigned     g_max  [2] = '{32'd65535, 32'd255};
    longint unsigned c_rst  [2] = '{64'd0, 64'hFFFF_FFF0};

    logic [W-1:0] exp_q_a[$];
    logic [W-1:0] exp_q_b[$];

    task automatic model_step();
        bit seen;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_dly1[i] = 0; m_dly2[i] = 0; m_pulse[i] = 0;
                m_er[i] = 0; m_ef[i] = 0; m_pf[i] = 0;
                m_run[i] = 0; m_gl[i] = 0; m_cnt[i] = c_rst[i];
            end else begin
                seen      = m_dly2[i];
                m_dly2[i] = m_dly1[i];
                m_dly1[i] = pulse_in;
                m_er[i] = 0; m_ef[i] = 0; m_pf[i] = 0;
                if (ena) begin
                    if (seen != m_pulse[i]) begin
                        if (m_run[i] >= int'(filt_len)) begin
                            m_pulse[i] = seen;
                            m_run[i]   = 0;
                            m_er[i]    = seen;
                            m_ef[i]    = !seen;
                        end else begin
                            m_run[i]++;
                        end
                    end else if (m_run[i] != 0) begin
                        m_run[i] = 0;
                        if (m_gl[i] < g_max[i]) m_gl[i]++;
                    end
                    m_pf[i]  = (m_cnt[i] == 64'hFFFF_FFFF);
                    m_cnt[i] = (m_cnt[i] + 1) % 64'h1_0000_0000;
                end
                if (glitch_clr) m_gl[i] = 0;
            end
        end
        exp_q_a.push_back({m_pulse[0], m_er[0], m_ef[0], m_pf[0],
                           m_cnt[0][31:0], m_gl[0][15:0]});
        exp_q_b.push_back({m_pulse[1], m_er[1], m_ef[1], m_pf[1],
                           m_cnt[1][31:0], m_gl[1][15:0]});
    endtask

    // ---------------- driver ----------------
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        forever begin
            @(negedge clk);
            if (exp_q_a.size() > 0) begin
                exp_v = exp_q_a.pop_front();
                act_v = {bus_a.pulse, bus_a.edge_rise, bus_a.edge_fall, bus_a.pulse_full,
                         bus_a.count, bus_a.glitch_cnt};
                n_checks++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL sb_a at %0t: got %h required %h", $time, act_v, exp_v);
                end
            end
            if (exp_q_b.size() > 0) begin
                exp_v = exp_q_b.pop_front();
                act_v = {bus_b.pulse, bus_b.edge_rise, bus_b.edge_fall, bus_b.pulse_full,
                         bus_b.count, 8'h00, bus_b.glitch_cnt};
                n_checks++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL sb_b at %0t: got %h required %h", $time, act_v, exp_v);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        int run_left;

        rst = 1'b1; ena = 1'b0; pulse_in = 1'b0; filt_len = 8'd0; glitch_clr = 1'b0;
        tick();
        check("reset_a", {bus_a.pulse, bus_a.edge_rise, bus_a.edge_fall, bus_a.pulse_full,
                          bus_a.count, bus_a.glitch_cnt}, 64'h0);
        rst = 1'b0;

        // Pass-through filter: three-edge latency, single-cycle strobe.
        ena = 1'b1; filt_len = 8'd0;
        ticks(3);
        pulse_in = 1'b1;
        tick();
        tick();
        check("pt_before", bus_a.pulse, 64'd0);
        tick();
        check("pt_pulse", bus_a.pulse, 64'd1);
        check("pt_rise", bus_a.edge_rise, 64'd1);
        tick();
        check("pt_rise_end", bus_a.edge_rise, 64'd0);
        check("pt_hold", bus_a.pulse, 64'd1);

        // filt_len=3: return low, then a 3-cycle glitch, then a 4-cycle pulse.
        filt_len = 8'd3;
        pulse_in = 1'b0;
        ticks(6);
        check("f3_low", bus_a.pulse, 64'd0);
        check("f3_fall_strobe", bus_a.edge_fall, 64'd1);
        pulse_in = 1'b1;
        ticks(3);
        pulse_in = 1'b0;
        ticks(6);
        check("f3_glitch_pulse", bus_a.pulse, 64'd0);
        check("f3_glitch_cnt", bus_a.glitch_cnt, 64'd1);
        pulse_in = 1'b1;
        ticks(4);
        pulse_in = 1'b0;
        tick();
        check("f3_not_yet", bus_a.pulse, 64'd0);
        tick();
        check("f3_flip", bus_a.pulse, 64'd1);
        check("f3_cnt_kept", bus_a.glitch_cnt, 64'd1);
        ticks(10);
        check("f3_back_low", bus_a.pulse, 64'd0);

        // ena gap in the middle of a mismatch run.
        pulse_in = 1'b1;
        ticks(3);
        ena = 1'b0;
        ticks(5);
        check("gap_pulse", bus_a.pulse, 64'd0);
        check("gap_full", bus_a.pulse_full, 64'd0);
        ena = 1'b1;
        ticks(2);
        check("gap_resume", bus_a.pulse, 64'd0);
        tick();
        check("gap_flip", bus_a.pulse, 64'd1);
        check("gap_rise", bus_a.edge_rise, 64'd1);

        // Reset while stab=2 and count=0x1234.
        guard = 0;
        while (bus_a.count != 32'h1230 && guard < 8000) begin
            tick();
            guard++;
        end
        check("reach_1230", bus_a.count, 64'h1230);
        pulse_in = 1'b0;
        ticks(4);
        check("pre_rst_count", bus_a.count, 64'h1234);
        check("pre_rst_pulse", bus_a.pulse, 64'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_a", {bus_a.pulse, bus_a.edge_rise, bus_a.edge_fall, bus_a.pulse_full,
                            bus_a.count, bus_a.glitch_cnt}, 64'h0);
        check("mid_rst_b_count", bus_b.count, 64'hFFFF_FFF0);
        check("mid_rst_b_full", bus_b.pulse_full, 64'd0);
        rst = 1'b0;
        tick();
        check("post_rst_count", bus_a.count, 64'd1);

        // Rollover on the preloaded instance.
        guard = 0;
        while (bus_b.count != 32'hFFFF_FFFF && guard < 20) begin
            tick();
            guard++;
        end
        check("wrap_max", bus_b.count, 64'hFFFF_FFFF);
        check("wrap_max_full", bus_b.pulse_full, 64'd0);
        tick();
        check("wrap_zero", bus_b.count, 64'd0);
        check("wrap_full", bus_b.pulse_full, 64'd1);
        tick();
        check("wrap_one", bus_b.count, 64'd1);
        check("wrap_full_end", bus_b.pulse_full, 64'd0);

        // Filter restarts cleanly after reset (filt_len still 3).
        pulse_in = 1'b1;
        ticks(5);
        check("restart_wait", bus_a.pulse, 64'd0);
        tick();
        check("restart_flip", bus_a.pulse, 64'd1);

        // Glitch saturation with filt_len=1: 257 one-cycle glitches.
        filt_len = 8'd1;
        pulse_in = 1'b0;
        ticks(10);
        glitch_clr = 1'b1;
        tick();
        glitch_clr = 1'b0;
        check("gclr", bus_a.glitch_cnt, 64'd0);
        for (int k = 0; k < 514; k++) begin
            pulse_in = (k % 2 == 0);
            tick();
        end
        pulse_in = 1'b0;
        ticks(4);
        check("sat_a", bus_a.glitch_cnt, 64'd257);
        check("sat_b", bus_b.glitch_cnt, 64'hFF);
        check("sat_pulse", bus_a.pulse, 64'd0);

        // Clear coincident with a glitch.
        pulse_in = 1'b1;
        tick();
        pulse_in = 1'b0;
        ticks(2);
        glitch_clr = 1'b1;
        tick();
        glitch_clr = 1'b0;
        check("clr_win_a", bus_a.glitch_cnt, 64'd0);
        check("clr_win_b", bus_b.glitch_cnt, 64'd0);
        ticks(3);
        check("clr_stays", bus_a.glitch_cnt, 64'd0);

        // Randomised traffic, checked by the scoreboard.
        run_left = 0;
        for (int k = 0; k < 3000; k++) begin
            if (run_left == 0) begin
                pulse_in = ~pulse_in;
                run_left = $urandom_range(1, 8);
            end
            run_left--;
            ena        = ($urandom_range(0, 9) != 0);
            glitch_clr = ($urandom_range(0, 99) == 0);
            rst        = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 99) == 0) filt_len = 8'($urandom_range(0, 5));
            tick();
        end
        rst = 1'b0; ena = 1'b0; glitch_clr = 1'b0;

        @(negedge clk);
        #1;
        if (exp_q_a.size() != 0 || exp_q_b.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_drain: %0d/%0d entries left, required 0/0",
                     exp_q_a.size(), exp_q_b.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_cond.md
Name: pulse_cond

Overview:
Front-end conditioning stage feeding the pulse period/width measurement block.
- Synchronises the asynchronous pulse input.
- Rejects glitches shorter than a programmable length.
- Generates the free-running timestamp counter (count) and its wrap strobe (pulse_full), which the measurement stage consumes alongside the cleaned pulse.
- Reports edge strobes and a rejected-glitch counter for diagnostics.

Parameters:
FILT_W, 8, width of filter length input and internal stability counter
GLITCH_W, 16, width of saturating glitch counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
ena  input  1  enable; gates filter and timestamp counter
pulse_in  input  1  raw asynchronous pulse
filt_len  input  FILT_W  required consecutive mismatch cycles minus one
glitch_clr  input  1  synchronous clear of glitch_cnt
pulse  output  1  synchronised, filtered pulse
edge_rise  output  1  one-cycle strobe, first cycle pulse=1
edge_fall  output  1  one-cycle strobe, first cycle pulse=0
count  output  32  free-running timestamp
pulse_full  output  1  one-cycle strobe on count wrap
glitch_cnt  output  GLITCH_W  number of rejected glitches, saturating

Behaviour:
- Reset (rst=1 at a rising edge) zeroes everything: sync flops, pulse, edge_rise, edge_fall, count, pulse_full, stability counter stab, glitch_cnt. Reset takes priority over all other inputs, including mid-filter.
- Synchroniser:
  - Two flops s1 <= pulse_in, s2 <= s1.
  - Always runs, independent of ena.
- Filter, evaluated only when ena=1; when ena=0, pulse and stab hold:
  - s2 != pulse and stab >= filt_len: pulse <= s2, stab <= 0.
  - s2 != pulse and stab < filt_len: stab <= stab+1.
  - s2 == pulse and stab != 0: glitch rejected; stab <= 0; glitch_cnt increments.
  - s2 == pulse and stab == 0: no change.
- Filter timing:
  - pulse flips on the (filt_len+1)th consecutive mismatching enabled cycle.
  - filt_len=0 gives pass-through.
  - Latency from a pulse_in edge to pulse is 2 + filt_len + 1 clocks, ena held high.
  - The ">=" compare makes lowering filt_len mid-count flip on the next mismatch cycle.
  - stab is FILT_W wide; it never exceeds filt_len, so it cannot overflow.
- Edge strobes:
  - Registered with pulse, so each strobe is high exactly in the first cycle of the new pulse level.
  - Otherwise both strobes are 0.
  - They are never both high.
- glitch_cnt:
  - Saturates at all-ones.
  - glitch_clr=1 sets it to 0, and wins over a simultaneous increment.
- count / pulse_full:
  - When ena=1, count <= count+1, wrapping 0xFFFFFFFF -> 0.
  - pulse_full=1 in the cycle count shows 0 after a wrap; otherwise 0.
  - When ena=0, count holds and pulse_full=0.
  - Post-reset count=0 does not assert pulse_full.
- Downstream sees pulse, count and pulse_full as registered signals from the same clock edge.

Test Plan:
- filt_len=0, ena=1, pulse_in rises at cycle 10 (set up before edge) -> pulse=1 and edge_rise=1 at cycle 13 only; edge_rise=0 at cycle 14.
- filt_len=3, pulse_in high for 3 cycles then low -> pulse stays 0, glitch_cnt=1. Then high for 4 cycles -> pulse=1 at 2+4 cycles after the rise, glitch_cnt still 1.
- Force count to 0xFFFFFFFE via reset then run 0xFFFFFFFE cycles (or a bench-only preload) -> count 0xFFFFFFFF then 0, pulse_full=1 for exactly the 0 cycle.
- ena=0 for 5 cycles during a mismatch run with filt_len=3 -> stab and count frozen. Resume -> flip occurs after the remaining mismatch cycles, total enabled mismatch cycles = 4.
- 0xFFFF+2 glitches with GLITCH_W=16 -> glitch_cnt=0xFFFF. glitch_clr coincident with a glitch -> glitch_cnt=0.
- rst=1 asserted while stab=2 and count=0x1234 -> next cycle every output is 0. Deassert -> count increments from 0 and the filter restarts.
